tcp_rx_app_msg_client: RTL and testbench

TCP_RX_APP_MSG_CLIENT -- requirements
Module: tcp_rx_app_msg_client

---
 rtl/tcp_rx_app_msg_client.sv | 170 +++++++++++++++++
 tb/tb_tcp_rx_app_msg_client.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rx_app_msg_client.sv
// rtl/tcp_rx_app_msg_client.sv - client tile that requests, hands out and frees TCP RX payload buffers over the NoC
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 128
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif

module tcp_rx_app_msg_client #(
  parameter int SRC_X            = 0,
  parameter int SRC_Y            = 0,
  parameter int DST_X            = 1,
  parameter int DST_Y            = 0,
  parameter int DST_FBITS        = 0,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int FLOWID_W         = 8,
  parameter int RX_PAYLOAD_PTR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          app_req_val,
  output logic                          app_req_rdy,
  input  logic [FLOWID_W-1:0]           app_req_flowid,
  input  logic [RX_PAYLOAD_PTR_W-1:0]   app_req_len,
  output logic                          client_noc_val,
  input  logic                          noc_client_rdy,
  output logic [`NOC_DATA_WIDTH-1:0]    client_noc_data,
  input  logic                          noc_client_val,
  output logic                          client_noc_rdy,
  input  logic [`NOC_DATA_WIDTH-1:0]    noc_client_data,
  output logic                          app_resp_val,
  input  logic                          app_resp_rdy,
  output logic [FLOWID_W-1:0]           app_resp_flowid,
  output logic [RX_PAYLOAD_PTR_W-1:0]   app_resp_addr,
  output logic [RX_PAYLOAD_PTR_W-1:0]   app_resp_len,
  input  logic                          app_done_val,
  output logic                          app_done_rdy,
  output logic [31:0]                   msg_cnt,
  output logic [15:0]                   retry_cnt,
  output logic                          flowid_err
);

  localparam int DW    = `NOC_DATA_WIDTH;
  localparam int PW    = RX_PAYLOAD_PTR_W;
  localparam int HDR_W = 8 + 4 * `XY_WIDTH + `NOC_FBITS_WIDTH + FLOWID_W + 2 * PW;
  localparam int PAD_W = DW - HDR_W;

  localparam logic [7:0] MSG_REQ  = 8'h01;
  localparam logic [7:0] MSG_RESP = 8'h02;
  localparam logic [7:0] MSG_ADV  = 8'h03;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT_RESP = 3'd2;
  localparam logic [2:0] S_APP_RESP  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_SEND_ADV  = 3'd5;

  logic [2:0]          state;
  logic [FLOWID_W-1:0] flowid_q;
  logic [PW-1:0]       addr_q;
  logic [PW-1:0]       len_q;
  logic [31:0]         tmo_cnt;

  logic [7:0]          in_type;
  logic [FLOWID_W-1:0] in_flowid;
  logic [PW-1:0]       in_addr;
  logic [PW-1:0]       in_len;
  logic                in_accept;
  logic                resp_hit;
  logic                resp_miss;
  logic                tmo_expire;
  logic                unused_in;

  // Inbound fields sit at the same offsets as the outbound layout.
  assign in_type   = noc_client_data[DW-1 -: 8];
  assign in_flowid = noc_client_data[PAD_W + 2*PW +: FLOWID_W];
  assign in_addr   = noc_client_data[PAD_W + PW +: PW];
  assign in_len    = noc_client_data[PAD_W +: PW];
  assign unused_in = ^noc_client_data;

  assign in_accept  = (state == S_WAIT_RESP) && noc_client_val;
  assign resp_hit   = in_accept && (in_type == MSG_RESP) && (in_flowid == flowid_q);
  assign resp_miss  = in_accept && (in_type == MSG_RESP) && (in_flowid != flowid_q);
  assign tmo_expire = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  logic [7:0]       out_type;
  logic [PW-1:0]    out_addr;
  logic [HDR_W-1:0] out_hdr;

  // REQ carries a zero address; everything else is held in registers, so data is stable under back-pressure.
  assign out_type = (state == S_SEND_ADV) ? MSG_ADV : MSG_REQ;
  assign out_addr = (state == S_SEND_ADV) ? addr_q : '0;
  assign out_hdr  = {out_type,
                     `XY_WIDTH'(DST_X), `XY_WIDTH'(DST_Y),
                     `XY_WIDTH'(SRC_X), `XY_WIDTH'(SRC_Y),
                     `NOC_FBITS_WIDTH'(DST_FBITS),
                     flowid_q, out_addr, len_q};
  assign client_noc_data = DW'(out_hdr) << PAD_W;

  assign app_req_rdy     = (state == S_IDLE);
  assign client_noc_val  = (state == S_SEND_REQ) || (state == S_SEND_ADV);
  assign client_noc_rdy  = (state == S_WAIT_RESP);
  assign app_resp_val    = (state == S_APP_RESP);
  assign app_resp_flowid = flowid_q;
  assign app_resp_addr   = addr_q;
  assign app_resp_len    = len_q;
  assign app_done_rdy    = (state == S_WAIT_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flowid_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      tmo_cnt    <= '0;
      msg_cnt    <= '0;
      retry_cnt  <= '0;
      flowid_err <= 1'b0;
    end else begin
      flowid_err <= resp_miss;
      case (state)
        S_IDLE: begin
          if (app_req_val) begin
            flowid_q <= app_req_flowid;
            len_q    <= app_req_len;
            addr_q   <= '0;
            state    <= S_SEND_REQ;
          end
        end
        S_SEND_REQ: begin
          if (noc_client_rdy) begin
            tmo_cnt <= '0;
            state   <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // A matching RESP wins over timeout expiry in the same cycle.
          if (resp_hit) begin
            addr_q <= in_addr;
            len_q  <= in_len;
            state  <= S_APP_RESP;
          end else if (tmo_expire) begin
            if (retry_cnt != 16'hFFFF) retry_cnt <= retry_cnt + 16'd1;
            state <= S_SEND_REQ;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_APP_RESP: begin
          if (app_resp_rdy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (app_done_val) state <= S_SEND_ADV;
        end
        S_SEND_ADV: begin
          if (noc_client_rdy) begin
            msg_cnt <= msg_cnt + 32'd1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_app_msg_client.sv
// tb/tb_tcp_rx_app_msg_client.sv - directed self-checking bench for tcp_rx_app_msg_client
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 128
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif

module tb_tcp_rx_app_msg_client;

  logic         clk = 1'b0;
  logic         rst;
  logic         app_req_val;
  logic         app_req_rdy;
  logic [7:0]   app_req_flowid;
  logic [15:0]  app_req_len;
  logic         client_noc_val;
  logic         noc_client_rdy;
  logic [127:0] client_noc_data;
  logic         noc_client_val;
  logic         client_noc_rdy;
  logic [127:0] noc_client_data;
  logic         app_resp_val;
  logic         app_resp_rdy;
  logic [7:0]   app_resp_flowid;
  logic [15:0]  app_resp_addr;
  logic [15:0]  app_resp_len;
  logic         app_done_val;
  logic         app_done_rdy;
  logic [31:0]  msg_cnt;
  logic [15:0]  retry_cnt;
  logic         flowid_err;

  int compared   = 0;
  int mismatched = 0;
  logic [127:0] held;

  always #5 clk = ~clk;

  tcp_rx_app_msg_client #(
    .SRC_X(2), .SRC_Y(3), .DST_X(1), .DST_Y(4), .DST_FBITS(5),
    .TIMEOUT_CYCLES(16), .FLOWID_W(8), .RX_PAYLOAD_PTR_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .app_req_val(app_req_val), .app_req_rdy(app_req_rdy),
    .app_req_flowid(app_req_flowid), .app_req_len(app_req_len),
    .client_noc_val(client_noc_val), .noc_client_rdy(noc_client_rdy),
    .client_noc_data(client_noc_data),
    .noc_client_val(noc_client_val), .client_noc_rdy(client_noc_rdy),
    .noc_client_data(noc_client_data),
    .app_resp_val(app_resp_val), .app_resp_rdy(app_resp_rdy),
    .app_resp_flowid(app_resp_flowid), .app_resp_addr(app_resp_addr),
    .app_resp_len(app_resp_len),
    .app_done_val(app_done_val), .app_done_rdy(app_done_rdy),
    .msg_cnt(msg_cnt), .retry_cnt(retry_cnt), .flowid_err(flowid_err)
  );

  // Expected flit: type, dst(1,4), src(2,3), fbits 5, flowid, addr, len, 44 zero bits.
  function automatic logic [127:0] flit(input logic [7:0] t, input logic [7:0] f,
                                        input logic [15:0] a, input logic [15:0] l);
    flit = {t, 8'd1, 8'd4, 8'd2, 8'd3, 4'd5, f, a, l, 44'd0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic request(input logic [7:0] f, input logic [15:0] l);
    app_req_val = 1'b1; app_req_flowid = f; app_req_len = l;
    tick();
    app_req_val = 1'b0;
    chk("req_flit_val", client_noc_val, 1'b1);
    chk("req_flit_data", client_noc_data, flit(8'h01, f, 16'h0, l));
    noc_client_rdy = 1'b1;
    tick();
    noc_client_rdy = 1'b0;
    chk("wait_resp_rdy", client_noc_rdy, 1'b1);
  endtask

  task automatic send_in(input logic [127:0] d);
    noc_client_val = 1'b1; noc_client_data = d;
    tick();
    noc_client_val = 1'b0;
  endtask

  task automatic finish_txn(input logic [7:0] f, input logic [15:0] a, input logic [15:0] l,
                            input logic [31:0] exp_cnt);
    chk("resp_val", app_resp_val, 1'b1);
    chk("resp_flowid", app_resp_flowid, f);
    chk("resp_addr", app_resp_addr, a);
    chk("resp_len", app_resp_len, l);
    app_resp_rdy = 1'b1; tick(); app_resp_rdy = 1'b0;
    chk("done_rdy", app_done_rdy, 1'b1);
    app_done_val = 1'b1; tick(); app_done_val = 1'b0;
    chk("adv_val", client_noc_val, 1'b1);
    chk("adv_data", client_noc_data, flit(8'h03, f, a, l));
    noc_client_rdy = 1'b1; tick(); noc_client_rdy = 1'b0;
    chk("msg_cnt", msg_cnt, exp_cnt);
    chk("back_idle", app_req_rdy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; app_req_val = 0; app_req_flowid = 0; app_req_len = 0;
    noc_client_rdy = 0; noc_client_val = 0; noc_client_data = '0;
    app_resp_rdy = 0; app_done_val = 0;
    tick(2);
    rst = 1'b0;
    chk("rst_req_rdy", app_req_rdy, 1'b1);
    chk("rst_noc_val", client_noc_val, 1'b0);
    chk("rst_noc_rdy", client_noc_rdy, 1'b0);
    chk("rst_msg_cnt", msg_cnt, 32'd0);
    chk("rst_retry", retry_cnt, 16'd0);

    // Inbound flits in IDLE are back-pressured.
    noc_client_val = 1'b1; noc_client_data = flit(8'h02, 8'd5, 16'h100, 16'd64);
    chk("idle_backpressure", client_noc_rdy, 1'b0);
    noc_client_val = 1'b0;

    // Basic transaction, with 10 cycles of ADV back-pressure.
    request(8'd5, 16'd64);
    send_in(flit(8'h02, 8'd5, 16'h100, 16'd64));
    chk("b_resp_val", app_resp_val, 1'b1);
    chk("b_resp_flowid", app_resp_flowid, 8'd5);
    chk("b_resp_addr", app_resp_addr, 16'h100);
    chk("b_resp_len", app_resp_len, 16'd64);
    app_resp_rdy = 1'b1; tick(); app_resp_rdy = 1'b0;
    app_done_val = 1'b1; tick(); app_done_val = 1'b0;
    held = flit(8'h03, 8'd5, 16'h100, 16'd64);
    for (int i = 0; i < 10; i++) begin
      chk("adv_hold_val", client_noc_val, 1'b1);
      chk("adv_hold_data", client_noc_data, held);
      chk("adv_hold_cnt", msg_cnt, 32'd0);
      tick();
    end
    noc_client_rdy = 1'b1; tick(); noc_client_rdy = 1'b0;
    chk("b_msg_cnt", msg_cnt, 32'd1);
    chk("b_idle", app_req_rdy, 1'b1);

    // Timeout with no RESP: re-send after 16 waiting cycles.
    request(8'd7, 16'd32);
    tick(15);
    chk("tmo_still_wait", client_noc_rdy, 1'b1);
    chk("tmo_no_retry_yet", retry_cnt, 16'd0);
    tick();
    chk("tmo_resend_val", client_noc_val, 1'b1);
    chk("tmo_resend_data", client_noc_data, flit(8'h01, 8'd7, 16'h0, 16'd32));
    chk("tmo_retry_cnt", retry_cnt, 16'd1);
    noc_client_rdy = 1'b1; tick(); noc_client_rdy = 1'b0;
    send_in(flit(8'h02, 8'd7, 16'h200, 16'd32));
    finish_txn(8'd7, 16'h200, 16'd32, 32'd2);

    // Mismatched RESP and a stray ADV are dropped; then a len-0 grant completes.
    request(8'd5, 16'd8);
    send_in(flit(8'h02, 8'd6, 16'h80, 16'd8));
    chk("mis_err_pulse", flowid_err, 1'b1);
    chk("mis_no_resp", app_resp_val, 1'b0);
    chk("mis_still_wait", client_noc_rdy, 1'b1);
    send_in(flit(8'h03, 8'd5, 16'h80, 16'd8));
    chk("mis_err_clear", flowid_err, 1'b0);
    chk("other_no_resp", app_resp_val, 1'b0);
    send_in(flit(8'h02, 8'd5, 16'h40, 16'd0));
    finish_txn(8'd5, 16'h40, 16'd0, 32'd3);

    // RESP arriving exactly in the expiry cycle wins.
    request(8'd9, 16'd16);
    tick(15);
    send_in(flit(8'h02, 8'd9, 16'h300, 16'd16));
    chk("edge_resp_val", app_resp_val, 1'b1);
    chk("edge_retry", retry_cnt, 16'd1);
    chk("edge_addr", app_resp_addr, 16'h300);

    // Reset in WAIT_DONE abandons the transaction.
    app_resp_rdy = 1'b1; tick(); app_resp_rdy = 1'b0;
    chk("rd_done_rdy", app_done_rdy, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rd_req_rdy", app_req_rdy, 1'b1);
    chk("rd_msg_cnt", msg_cnt, 32'd0);
    chk("rd_retry", retry_cnt, 16'd0);
    chk("rd_done_rdy0", app_done_rdy, 1'b0);
    chk("rd_resp_fields", {app_resp_flowid, app_resp_addr, app_resp_len}, 40'd0);
    app_done_val = 1'b1; noc_client_rdy = 1'b1;
    tick(3);
    chk("rd_no_adv", client_noc_val, 1'b0);
    chk("rd_cnt_hold", msg_cnt, 32'd0);
    app_done_val = 1'b0; noc_client_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
